// File: rtl/sa_drain_pkg.sv
// ============================================================================
// sa_drain_pkg : shared types and sizing helpers for the systolic result drain
// Revision: 1.0
// ============================================================================
`default_nettype none

package sa_drain_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int num_elems(input int hpe, input int vpe);
    return hpe * vpe;
  endfunction

  // Index buses never collapse to zero width, even for a single row/column.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Element 0 sits in the MSBs of the flattened bus.
  function automatic int elem_lsb(input int n, input int e, input int elem_w);
    return (n - e - 1) * elem_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_drain_buf.sv
// ============================================================================
// sa_drain_buf : one full result-set capture register plus element select mux
// Revision: 1.0
// ============================================================================
`default_nettype none

module sa_drain_buf
  import sa_drain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HPE   = 8,
  parameter int VPE   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_load,
  input  logic [2*WIDTH*HPE*VPE-1:0]            i_y,
  input  logic [idx_width(HPE*VPE)-1:0]         i_idx,
  output logic [2*WIDTH-1:0]                    o_elem
);

  localparam int C_N  = num_elems(HPE, VPE);
  localparam int C_IW = idx_width(C_N);
  localparam int C_DW = 2 * WIDTH;

  logic [C_DW*C_N-1:0] r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y <= '0;
    end else if (i_load) begin
      r_y <= i_y;
    end
  end

  always_comb begin
    o_elem = '0;
    for (int e = 0; e < C_N; e++) begin
      if (i_idx == C_IW'(e)) begin
        o_elem = r_y[elem_lsb(C_N, e, C_DW) +: C_DW];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sa_result_drain.sv
// ============================================================================
// sa_result_drain : captures the systolic array result bus and streams it out
// one element per beat, row-major. SA_DRAIN_PINGPONG_EN selects two buffers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sa_result_drain
  import sa_drain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HPE   = 8,
  parameter int VPE   = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [2*WIDTH*HPE*VPE-1:0]    Y_IN,
  input  logic                          Y_VALID,
  output logic                          Y_READY,
  output logic [2*WIDTH-1:0]            OUT_DATA,
  output logic [idx_width(VPE)-1:0]     OUT_ROW,
  output logic [idx_width(HPE)-1:0]     OUT_COL,
  output logic                          OUT_LAST,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic                          BUSY
);

  localparam int C_N  = num_elems(HPE, VPE);
  localparam int C_IW = idx_width(C_N);
  localparam int C_RW = idx_width(VPE);
  localparam int C_CW = idx_width(HPE);
  localparam int C_DW = 2 * WIDTH;

  logic              r_live;
  logic [C_RW-1:0]   r_row;
  logic [C_CW-1:0]   r_col;
  logic [C_IW-1:0]   w_idx;
  logic              w_cap;
  logic              w_accept;
  logic              w_at_last;
  logic              w_last_acc;

  assign w_cap      = Y_VALID && Y_READY;
  assign w_accept   = OUT_VALID && OUT_READY;
  assign w_at_last  = (r_row == C_RW'(VPE - 1)) && (r_col == C_CW'(HPE - 1));
  assign w_last_acc = w_accept && w_at_last;
  assign w_idx      = C_IW'(r_row) * C_IW'(HPE) + C_IW'(r_col);

  // Holds Y_READY low through reset and releases it on the first edge after.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_at_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == C_CW'(HPE - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign OUT_ROW  = r_row;
  assign OUT_COL  = r_col;
  assign OUT_LAST = OUT_VALID && w_at_last;

`ifdef SA_DRAIN_PINGPONG_EN
  logic [1:0]        r_full;
  logic              r_wsel;
  logic              r_rsel;
  logic [C_DW-1:0]   w_elem0;
  logic [C_DW-1:0]   w_elem1;

  // Capture targets wsel and the last beat frees rsel; they never coincide
  // because one needs an empty buffer and the other a full one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_full <= 2'b00;
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
    end else begin
      if (w_cap) begin
        r_full[r_wsel] <= 1'b1;
        r_wsel         <= ~r_wsel;
      end
      if (w_last_acc) begin
        r_full[r_rsel] <= 1'b0;
        r_rsel         <= ~r_rsel;
      end
    end
  end

  assign Y_READY   = r_live && !r_full[r_wsel];
  assign OUT_VALID = r_full[r_rsel];
  assign BUSY      = |r_full;
  assign OUT_DATA  = r_rsel ? w_elem1 : w_elem0;

  sa_drain_buf #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) u_buf0 (
    .clk    (CLK),
    .rst    (RST),
    .i_load (w_cap && !r_wsel),
    .i_y    (Y_IN),
    .i_idx  (w_idx),
    .o_elem (w_elem0)
  );

  sa_drain_buf #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) u_buf1 (
    .clk    (CLK),
    .rst    (RST),
    .i_load (w_cap && r_wsel),
    .i_y    (Y_IN),
    .i_idx  (w_idx),
    .o_elem (w_elem1)
  );
`else
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cap)      w_state_nxt = DRAIN;
      DRAIN:   if (w_last_acc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Y_READY   = r_live && (r_state == IDLE);
  assign OUT_VALID = (r_state == DRAIN);
  assign BUSY      = (r_state == DRAIN);

  sa_drain_buf #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) u_buf0 (
    .clk    (CLK),
    .rst    (RST),
    .i_load (w_cap),
    .i_y    (Y_IN),
    .i_idx  (w_idx),
    .o_elem (OUT_DATA)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_sa_result_drain.sv
// ============================================================================
// tb_sa_result_drain : scoreboard bench for sa_result_drain (WIDTH=16, 2x2)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sa_result_drain;

  localparam int WIDTH = 16;
  localparam int HPE   = 2;
  localparam int VPE   = 2;
  localparam int YW    = 2 * WIDTH * HPE * VPE;

  typedef struct packed {
    logic [31:0] data;
    logic        row;
    logic        col;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [YW-1:0] y_in = '0;
  logic          y_valid = 1'b0;
  logic          y_ready;
  logic [31:0]   out_data;
  logic          out_row;
  logic          out_col;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_beats  = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  sa_result_drain #(.WIDTH(WIDTH), .HPE(HPE), .VPE(VPE)) dut (
    .CLK       (clk),
    .RST       (rst),
    .Y_IN      (y_in),
    .Y_VALID   (y_valid),
    .Y_READY   (y_ready),
    .OUT_DATA  (out_data),
    .OUT_ROW   (out_row),
    .OUT_COL   (out_col),
    .OUT_LAST  (out_last),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .BUSY      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_set(input logic [YW-1:0] d);
    for (int e = 0; e < 4; e++) begin
      beat_t b;
      b.data = d[(3 - e) * 32 +: 32];
      b.row  = 1'(e / 2);
      b.col  = 1'(e % 2);
      b.last = (e == 3);
      q.push_back(b);
    end
  endtask

  // Holds the set on Y_IN until a handshake; expectations are queued once
  // the capture edge is certain.
  task automatic offer(input logic [YW-1:0] d);
    bit done = 1'b0;
    y_in    = d;
    y_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (y_ready) begin
        push_set(d);
        done = 1'b1;
      end
    end
    check("offer_handshake", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    y_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((busy || q.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    check(tag, 64'(k < 100), 64'd1);
    q.delete();
  endtask

  // Every presented beat must match the queue head, including while stalled.
  always @(negedge clk) begin
    beat_t f;
    if (!rst && out_valid) begin
      check("beat_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        f = q[0];
        check("out_data", 64'(out_data), 64'(f.data));
        check("out_row",  64'(out_row),  64'(f.row));
        check("out_col",  64'(out_col),  64'(f.col));
        check("out_last", 64'(out_last), 64'(f.last));
        if (out_ready) begin
          void'(q.pop_front());
          n_beats++;
        end
      end
    end
  end

  initial begin
    int b0;
    repeat (3) tick();
    check("rst_y_ready",   64'(y_ready),   64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_row",   64'(out_row),   64'd0);
    check("rst_out_col",   64'(out_col),   64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_y_ready", 64'(y_ready), 64'd1);

    // Basic drain: 1-cycle latency, one beat per cycle
    out_ready = 1'b1;
    offer(128'h00000001_00000002_00000003_00000004);
    check("basic_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("basic_valid", 64'(out_valid), 64'd1);
      tick();
    end
    check("basic_done_valid", 64'(out_valid), 64'd0);
    check("basic_y_ready",    64'(y_ready),   64'd1);
    check("basic_busy_low",   64'(busy),      64'd0);
    check("basic_beats",      64'(n_beats),   64'd4);

    // Backpressure: ready toggles, drain takes 8 cycles
    b0 = n_beats;
    out_ready = 1'b0;
    offer(128'hA5A5_0001_5A5A_0002_DEAD_BEEF_CAFE_F00D);
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 2 == 1);
      tick();
    end
    check("bp_busy_low", 64'(busy),         64'd0);
    check("bp_beats",    64'(n_beats - b0), 64'd4);
    out_ready = 1'b1;

`ifndef SA_DRAIN_PINGPONG_EN
    // Capture blocked while draining; new set follows the current one
    b0 = n_beats;
    out_ready = 1'b0;
    offer(128'h11111111_22222222_33333333_44444444);
    fork
      offer(128'h55555555_66666666_77777777_88888888);
      begin
        repeat (3) tick();
        check("blk_y_ready", 64'(y_ready), 64'd0);
        check("blk_busy",    64'(busy),    64'd1);
        out_ready = 1'b1;
      end
    join
    wait_drain("blk_drain");
    check("blk_beats", 64'(n_beats - b0), 64'd8);
`endif

    // Reset after beat 2: remaining beats never appear
    out_ready = 1'b1;
    offer(128'h0BAD0001_0BAD0002_0BAD0003_0BAD0004);
    tick();
    tick();
    b0 = n_beats;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",   64'(out_valid), 64'd0);
    check("mid_rst_busy",    64'(busy),      64'd0);
    check("mid_rst_y_ready", 64'(y_ready),   64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("rel_y_ready", 64'(y_ready),   64'd1);
    check("rel_busy",    64'(busy),      64'd0);
    check("rel_valid",   64'(out_valid), 64'd0);
    repeat (4) tick();
    check("rel_no_beats", 64'(n_beats - b0), 64'd0);

`ifdef SA_DRAIN_PINGPONG_EN
    // Ping-pong streaming: 8 beats with no bubble
    b0 = n_beats;
    out_ready = 1'b1;
    offer(128'hAAAA0000_AAAA0001_AAAA0002_AAAA0003);
    fork
      offer(128'hBBBB0000_BBBB0001_BBBB0002_BBBB0003);
      for (int i = 0; i < 8; i++) begin
        check("pp_stream_valid", 64'(out_valid), 64'd1);
        tick();
      end
    join
    check("pp_stream_end",   64'(out_valid),    64'd0);
    check("pp_stream_beats", 64'(n_beats - b0), 64'd8);

    // Ping-pong full: third set waits for a free buffer
    b0 = n_beats;
    out_ready = 1'b0;
    offer(128'hC0C00000_C0C00001_C0C00002_C0C00003);
    offer(128'hD0D00000_D0D00001_D0D00002_D0D00003);
    check("pp_full_ready", 64'(y_ready), 64'd0);
    fork
      offer(128'hE0E00000_E0E00001_E0E00002_E0E00003);
      begin
        repeat (3) tick();
        check("pp_full_ready_held", 64'(y_ready), 64'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain("pp_full_drain");
    check("pp_full_beats", 64'(n_beats - b0), 64'd12);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
